// File: rtl/uart_pkg.sv
// Shared UART constants and RX FSM state encodings.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam logic        START_BIT      = 1'b0;
  localparam logic        STOP_BIT       = 1'b1;
  localparam logic        IDLE_LEVEL     = 1'b1;

  // RX FSM state encodings
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_depacketizer_rx_if.sv
// Byte stream from the receiver to its consumer, plus upstream flow control.
interface uart_depacketizer_rx_if;
  import uart_pkg::*;

  logic                      rx_ready;
  logic [UART_DATA_BITS-1:0] data_out;
  logic                      data_valid;
  logic                      data_ready;

  modport master (output rx_ready, output data_out, output data_valid, input data_ready);
  modport slave  (input rx_ready, input data_out, input data_valid, output data_ready);

endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_wr;
  logic             do_rd;

  // A pop frees the slot the simultaneous push needs, so full+pop still accepts.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | rd_en);

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_depacketizer_rx.sv
// 8N1 UART receiver: line synchronizer, bit-timing FSM and output byte FIFO.
module uart_depacketizer_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   serial_in,
  uart_depacketizer_rx_if.master bus,
  output logic                   rx_busy,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic                      sync_q1;
  logic                      rxd;
  logic                      rxd_prev;
  logic [1:0]                state, state_nxt;
  logic [CNT_W-1:0]          clk_cnt, clk_cnt_nxt;
  logic [2:0]                bit_cnt, bit_cnt_nxt;
  logic [UART_DATA_BITS-1:0] shreg, shreg_nxt;
  logic                      frame_err_nxt;
  logic                      overrun_nxt;
  logic                      push_c;
  logic                      pop_c;
  logic                      fifo_full;
  logic                      fifo_empty;

  assign pop_c          = bus.data_ready & ~fifo_empty;
  assign bus.rx_ready   = ~fifo_full;
  assign bus.data_valid = ~fifo_empty;
  assign rx_busy        = (state != RX_IDLE);

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1  <= IDLE_LEVEL;
      rxd      <= IDLE_LEVEL;
      rxd_prev <= IDLE_LEVEL;
    end else begin
      sync_q1  <= serial_in;
      rxd      <= sync_q1;
      rxd_prev <= rxd;
    end
  end

  // FSM state, bit timing counters, shift register and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RX_IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      clk_cnt   <= clk_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      frame_err <= frame_err_nxt;
      overrun   <= overrun_nxt;
    end
  end

  // Next-state logic: mid-start validation, mid-bit data sampling, stop check.
  always_comb begin
    state_nxt     = state;
    clk_cnt_nxt   = clk_cnt;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    frame_err_nxt = 1'b0;
    overrun_nxt   = 1'b0;
    push_c        = 1'b0;
    case (state)
      RX_IDLE: begin
        if (rxd_prev && !rxd) begin
          state_nxt   = RX_START;
          clk_cnt_nxt = '0;
        end
      end
      RX_START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_nxt = '0;
          if (rxd == START_BIT) begin
            state_nxt   = RX_DATA;
            bit_cnt_nxt = '0;
          end else begin
            state_nxt = RX_IDLE;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt = '0;
          shreg_nxt   = {rxd, shreg[UART_DATA_BITS-1:1]};
          if (bit_cnt == 3'd7) state_nxt = RX_STOP;
          else                 bit_cnt_nxt = bit_cnt + 3'd1;
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      default: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt = '0;
          state_nxt   = RX_IDLE;
          if (rxd == STOP_BIT) begin
            if (!fifo_full || pop_c) push_c      = 1'b1;
            else                     overrun_nxt = 1'b1;
          end else begin
            frame_err_nxt = 1'b1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
    endcase
  end

  uart_rx_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (push_c),
    .din   (shreg),
    .rd_en (bus.data_ready),
    .dout  (bus.data_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_uart_depacketizer_rx.sv
// Scoreboard bench for uart_depacketizer_rx with directed 8N1 frames.
module tb_uart_depacketizer_rx;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serial_in = 1'b1;
  logic rx_busy;
  logic frame_err;
  logic overrun;

  uart_depacketizer_rx_if bus ();

  uart_depacketizer_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .bus       (bus),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         lat;
  logic       busy_seen;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one frame starting at the current negedge; leaves the line idle.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    serial_in = stop_bit;
    repeat (CPB) @(negedge clk);
    serial_in = 1'b1;
  endtask

  // Drain the FIFO and check how many bytes came out; returns on a negedge.
  task automatic pop_all(input string name, input int exp_pops);
    int pops;
    pops = 0;
    @(posedge clk);
    #1 bus.data_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.data_valid) break;
      pops++;
    end
    @(posedge clk);
    #1 bus.data_ready = 1'b0;
    @(negedge clk);
    check({name, "_pops"}, 32'(pops), 32'(exp_pops));
    check({name, "_valid_after"}, 32'(bus.data_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
    check({name, "_data_out"}, 32'(bus.data_out), 32'h0);
    check({name, "_data_valid"}, 32'(bus.data_valid), 32'd0);
    check({name, "_rx_busy"}, 32'(rx_busy), 32'd0);
    check({name, "_frame_err"}, 32'(frame_err), 32'd0);
    check({name, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  // Monitor: compares every popped byte against the scoreboard and tallies flags.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.data_valid && bus.data_ready) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_byte", 32'(bus.data_out), 32'hFFFF_FFFF);
          end else begin
            check("sb_byte", 32'(bus.data_out), 32'(exp_q.pop_front()));
          end
        end
        if (frame_err || overrun) check("flag_exclusive", 32'(frame_err & overrun), 32'd0);
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.data_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: single frame, latency from start-bit edge to data_valid
    exp_q.push_back(8'hAC);
    lat = 0;
    fork
      send_frame(8'hAC, 1'b1);
      begin
        for (int i = 1; i <= 200; i++) begin
          @(negedge clk);
          if (bus.data_valid) begin
            lat = i;
            break;
          end
        end
      end
    join
    check("t1_latency", 32'(lat), 32'd155);
    check("t1_data_out", 32'(bus.data_out), 32'hAC);
    pop_all("t1", 1);

    // 2: back-to-back frames queued, then drained in order
    exp_q.push_back(8'hAC);
    exp_q.push_back(8'hCA);
    send_frame(8'hAC, 1'b1);
    send_frame(8'hCA, 1'b1);
    repeat (2) @(negedge clk);
    check("t2_valid", 32'(bus.data_valid), 32'd1);
    check("t2_head", 32'(bus.data_out), 32'hAC);
    pop_all("t2", 2);

    // 3: short glitch aborts in START
    busy_seen = 1'b0;
    serial_in = 1'b0;
    repeat (4) @(negedge clk);
    serial_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      busy_seen = busy_seen | rx_busy;
    end
    check("t3_busy_seen", 32'(busy_seen), 32'd1);
    check("t3_busy_end", 32'(rx_busy), 32'd0);
    check("t3_valid", 32'(bus.data_valid), 32'd0);

    // 4: framing error drops the byte, next frame still received
    send_frame(8'h55, 1'b0);
    repeat (2) @(negedge clk);
    check("t4_fe_count", 32'(fe_cnt), 32'd1);
    check("t4_valid", 32'(bus.data_valid), 32'd0);
    repeat (20) @(negedge clk);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    pop_all("t4", 1);

    // 5: fill the FIFO, then overrun on the fifth frame
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    repeat (2) @(negedge clk);
    check("t5_rx_ready_full", 32'(bus.rx_ready), 32'd0);
    send_frame(8'h05, 1'b1);
    repeat (2) @(negedge clk);
    check("t5_ov_count", 32'(ov_cnt), 32'd1);
    pop_all("t5", 4);

    // 6: reset in the middle of data bit 3 of 0xF0
    serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) repeat (CPB) @(negedge clk);
    repeat (CPB / 2) @(negedge clk);
    check("t6_busy_before_rst", 32'(rx_busy), 32'd1);
    rst = 1'b1;
    serial_in = 1'b1;
    @(negedge clk);
    check_reset_outputs("t6_rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    pop_all("t6", 1);

    repeat (5) @(negedge clk);
    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    check("fe_total", 32'(fe_cnt), 32'd1);
    check("ov_total", 32'(ov_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
